// File: rtl/alu.sv
// 32-bit integer ALU for the execute stage: combinational result and flags,
// plus copies registered on enable for the next pipeline stage.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             ovf,
    output logic [WIDTH-1:0] y_q,
    output logic             zero_q,
    output logic             ovf_q
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_SLTU  = 4'd7;
    localparam logic [3:0] ALU_SLL   = 4'd8;
    localparam logic [3:0] ALU_SRL   = 4'd9;
    localparam logic [3:0] ALU_SRA   = 4'd10;
    localparam logic [3:0] ALU_LUI   = 4'd11;
    localparam logic [3:0] ALU_PASSA = 4'd12;
    localparam logic [3:0] ALU_PASSB = 4'd13;

    logic [SW-1:0]    sh;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             slt;
    logic             sltu;

    assign sh   = a[SW-1:0];
    assign sum  = a + b;
    assign diff = a - b;
    assign slt  = $signed(a) < $signed(b);
    assign sltu = a < b;

    // Result mux; unused codes fall through to the zero default so no X leaks out.
    always_comb begin
        y   = '0;
        ovf = 1'b0;
        case (op)
            ALU_ADD: begin
                y   = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                y   = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND:   y = a & b;
            ALU_OR:    y = a | b;
            ALU_XOR:   y = a ^ b;
            ALU_NOR:   y = ~(a | b);
            ALU_SLT:   y = {{(WIDTH-1){1'b0}}, slt};
            ALU_SLTU:  y = {{(WIDTH-1){1'b0}}, sltu};
            ALU_SLL:   y = b << sh;
            ALU_SRL:   y = b >> sh;
            ALU_SRA:   y = $signed(b) >>> sh;
            ALU_LUI:   y = b << 16;
            ALU_PASSA: y = a;
            ALU_PASSB: y = b;
            default: begin
                y   = '0;
                ovf = 1'b0;
            end
        endcase
    end

    assign zero = (y == '0);

    // Reset value mirrors the flags of an all-zero result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q    <= '0;
            zero_q <= 1'b1;
            ovf_q  <= 1'b0;
        end else if (en) begin
            y_q    <= y;
            zero_q <= zero;
            ovf_q  <= ovf;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vector table, randomized comparison
// against an arithmetic reference model, and register/reset sequences.
module tb_alu;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] y;
    logic        zero;
    logic        ovf;
    logic [31:0] y_q;
    logic        zero_q;
    logic        ovf_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
        logic        z;
        logic        o;
    } vec_t;

    vec_t vecs[$];

    alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .op(op),
        .y(y), .zero(zero), .ovf(ovf), .y_q(y_q), .zero_q(zero_q), .ovf_q(ovf_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference computed with wide signed/unsigned integer arithmetic.
    function automatic void refAlu(input logic [3:0] rop, input logic [31:0] ra, input logic [31:0] rb,
                                   output logic [31:0] ry, output logic rz, output logic ro);
        longint sa;
        longint sb;
        longint r;
        longint p;
        longint q;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned prod;
        int s;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        ua = longint'(ra);
        ub = longint'(rb);
        s  = int'(ra % 32);
        ro = 1'b0;
        ry = 32'd0;
        case (rop)
            4'd0: begin
                r  = sa + sb;
                ro = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                prod = ua + ub;
                ry = prod[31:0];
            end
            4'd1: begin
                r  = sa - sb;
                ro = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                r  = r + 64'sd4294967296;
                ry = r[31:0];
            end
            4'd2: ry = ra & rb;
            4'd3: ry = ra | rb;
            4'd4: ry = ra ^ rb;
            4'd5: ry = ~(ra | rb);
            4'd6: ry = (sa < sb) ? 32'd1 : 32'd0;
            4'd7: ry = (ua < ub) ? 32'd1 : 32'd0;
            4'd8: begin
                prod = ub * (64'd1 << s);
                ry = prod[31:0];
            end
            4'd9: begin
                prod = ub / (64'd1 << s);
                ry = prod[31:0];
            end
            4'd10: begin
                p = longint'(64'd1 << s);
                q = sb / p;
                if (sb < 0 && (sb % p) != 0) q = q - 1;
                ry = q[31:0];
            end
            4'd11: begin
                prod = (ub % 65536) * 65536;
                ry = prod[31:0];
            end
            4'd12: ry = ra;
            4'd13: ry = rb;
            default: ry = 32'd0;
        endcase
        rz = (ry == 32'd0);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] sop, input logic [31:0] sa, input logic [31:0] sb);
        op = sop;
        a  = sa;
        b  = sb;
        #1;
    endtask

    task automatic checkRegs(input string name, input logic [31:0] ey, input logic ez, input logic eo);
        checkOutput({name, ".y_q"}, y_q, ey);
        checkOutput({name, ".zero_q"}, {31'd0, zero_q}, {31'd0, ez});
        checkOutput({name, ".ovf_q"}, {31'd0, ovf_q}, {31'd0, eo});
    endtask

    task automatic checkComb(input string name, input logic [31:0] ey, input logic ez, input logic eo);
        checkOutput({name, ".y"}, y, ey);
        checkOutput({name, ".zero"}, {31'd0, zero}, {31'd0, ez});
        checkOutput({name, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
    endtask

    initial begin
        logic [31:0] ey;
        logic        ez;
        logic        eo;
        logic [31:0] my;
        logic        mz;
        logic        mo;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;

        vecs.push_back('{"sll1",     4'd8,  32'h1,        32'h1,        32'h2,        1'b0, 1'b0});
        vecs.push_back('{"srl1",     4'd9,  32'h1,        32'h2,        32'h1,        1'b0, 1'b0});
        vecs.push_back('{"sra1",     4'd10, 32'h1,        32'h80000000, 32'hC0000000, 1'b0, 1'b0});
        vecs.push_back('{"srl_msb",  4'd9,  32'h1,        32'h80000000, 32'h40000000, 1'b0, 1'b0});
        vecs.push_back('{"sll_sh0",  4'd8,  32'h20,       32'h1234,     32'h1234,     1'b0, 1'b0});
        vecs.push_back('{"sra31",    4'd10, 32'hFFFFFFDF, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0});
        vecs.push_back('{"add_ovf",  4'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 1'b0, 1'b1});
        vecs.push_back('{"add_wrap", 4'd0,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0});
        vecs.push_back('{"sub_ovf",  4'd1,  32'h80000000, 32'h1,        32'h7FFFFFFF, 1'b0, 1'b1});
        vecs.push_back('{"sub_neg",  4'd1,  32'h5,        32'h7,        32'hFFFFFFFE, 1'b0, 1'b0});
        vecs.push_back('{"slt_neg",  4'd6,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0, 1'b0});
        vecs.push_back('{"sltu",     4'd7,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1'b0});
        vecs.push_back('{"slt_eq",   4'd6,  32'h5,        32'h5,        32'h0,        1'b1, 1'b0});
        vecs.push_back('{"and",      4'd2,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0});
        vecs.push_back('{"or",       4'd3,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0});
        vecs.push_back('{"xor",      4'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0});
        vecs.push_back('{"nor",      4'd5,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0});
        vecs.push_back('{"lui",      4'd11, 32'h0,        32'h00001234, 32'h12340000, 1'b0, 1'b0});
        vecs.push_back('{"passa",    4'd12, 32'hDEADBEEF, 32'h1,        32'hDEADBEEF, 1'b0, 1'b0});
        vecs.push_back('{"passb",    4'd13, 32'h1,        32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0});
        vecs.push_back('{"op14",     4'd14, 32'h1,        32'h2,        32'h0,        1'b1, 1'b0});
        vecs.push_back('{"op15",     4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        1'b1, 1'b0});

        rst_n = 1'b1;
        en    = 1'b0;
        op    = 4'd0;
        a     = 32'd0;
        b     = 32'd0;

        // Asynchronous reset between clock edges.
        #2 rst_n = 1'b0;
        #1;
        checkRegs("async_reset", 32'h0, 1'b1, 1'b0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkComb(vecs[i].name, vecs[i].y, vecs[i].z, vecs[i].o);
        end

        for (int i = 0; i < 300; i++) begin
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0: ra = $urandom_range(0, 40);
                1: ra = 32'h80000000 | ($urandom_range(0, 3));
                2: ra = 32'h7FFFFFFF - $urandom_range(0, 3);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 2))
                0: rb = ra;
                1: rb = $urandom_range(0, 3) == 0 ? 32'h80000000 : 32'hFFFFFFFF - $urandom_range(0, 2);
                default: rb = $urandom;
            endcase
            applyStimulus(rop, ra, rb);
            refAlu(rop, ra, rb, my, mz, mo);
            checkComb($sformatf("rand%0d_op%0d", i, rop), my, mz, mo);
        end

        // Release reset, capture ADD 2+3 after one edge.
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        applyStimulus(4'd0, 32'd2, 32'd3);
        @(posedge clk);
        #1;
        checkRegs("cap_add", 32'd5, 1'b0, 1'b0);

        @(negedge clk);
        en = 1'b0;
        applyStimulus(4'd0, 32'h7FFFFFFF, 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        checkRegs("hold", 32'd5, 1'b0, 1'b0);

        @(negedge clk);
        en = 1'b1;
        @(posedge clk);
        #1;
        checkRegs("cap_ovf", 32'h80000000, 1'b0, 1'b1);

        @(negedge clk);
        applyStimulus(4'd15, 32'h1234, 32'h5678);
        @(posedge clk);
        #1;
        checkRegs("cap_unused", 32'h0, 1'b1, 1'b0);

        @(negedge clk);
        applyStimulus(4'd0, 32'd2, 32'd3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkRegs("mid_reset", 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        checkRegs("reset_over_en", 32'h0, 1'b1, 1'b0);

        // Random enable/operand sequence tracked against the model.
        @(negedge clk);
        rst_n = 1'b1;
        ey = 32'h0;
        ez = 1'b1;
        eo = 1'b0;
        for (int i = 0; i < 60; i++) begin
            en  = 1'($urandom_range(0, 1));
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            applyStimulus(rop, ra, rb);
            refAlu(rop, ra, rb, my, mz, mo);
            if (en) begin
                ey = my;
                ez = mz;
                eo = mo;
            end
            @(posedge clk);
            #1;
            checkRegs($sformatf("seq%0d", i), ey, ez, eo);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
